// File: rtl/uart_program_loader.sv
// UART boot loader: receives a length-prefixed 9-bit word image over RX, writes it
// into the program SRAM and holds the processor in reset until the image is complete.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 9
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              rx,
  input  logic              reload,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              proc_resetn,
  output logic              busy,
  output logic              error
);

  // state   | meaning
  // COUNT   | waiting for the word-count byte (0 means full depth)
  // LO      | waiting for the low data byte of the current word
  // HI      | waiting for the high byte (only bit 0 may be set)
  // WRITE   | one-cycle SRAM write strobe for the current word
  // DONE    | image complete, processor released
  // ERROR   | malformed stream, processor held in reset

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]       DEPTH     = 9'(1 << ADDR_W);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_COUNT, S_LO, S_HI, S_WRITE, S_DONE, S_ERROR} ld_state_t;

  logic             rx_meta_q, rx_sync_q, rx_last_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid, frame_err;

  ld_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic             wr_en_q, proc_rstn_q, busy_q, error_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_last_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_last_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  // Down-counter reaches zero at each sample point; the start bit is re-checked at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_last_q && !rx_sync_q) begin
          cnt_d      = HALF_LAST;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = R_IDLE;
          end else begin
            cnt_d      = BIT_LAST;
            bit_d      = '0;
            rx_state_d = R_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = BIT_LAST;
          if (bit_q == 3'd7) rx_state_d = R_STOP;
          else               bit_d      = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) byte_valid = 1'b1;
          else           frame_err  = 1'b1;
          rx_state_d = R_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_COUNT;
      addr_q      <= '0;
      last_q      <= '0;
      din_q       <= '0;
      wr_en_q     <= 1'b0;
      proc_rstn_q <= 1'b0;
      busy_q      <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      din_q       <= din_d;
      wr_en_q     <= (state_d == S_WRITE);
      proc_rstn_q <= (state_d == S_DONE);
      busy_q      <= !((state_d == S_DONE) || (state_d == S_ERROR));
      error_q     <= (state_d == S_ERROR);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    din_d   = din_q;
    case (state_q)
      S_COUNT: begin
        if (frame_err) begin
          state_d = S_ERROR;
        end else if (byte_valid) begin
          if (shift_q == 8'd0) begin
            last_d  = '1;
            state_d = S_LO;
          end else if ({1'b0, shift_q} > DEPTH) begin
            state_d = S_ERROR;
          end else begin
            last_d  = ADDR_W'(shift_q - 8'd1);
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (frame_err) begin
          state_d = S_ERROR;
        end else if (byte_valid) begin
          din_d[7:0] = shift_q;
          state_d    = S_HI;
        end
      end
      S_HI: begin
        if (frame_err) begin
          state_d = S_ERROR;
        end else if (byte_valid) begin
          if (shift_q[7:1] != 7'd0) begin
            state_d = S_ERROR;
          end else begin
            din_d[DATA_W-1] = shift_q[0];
            state_d         = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // Address is not advanced after the last word so it reads back the final location.
        if (addr_q == last_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LO;
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          addr_d  = '0;
          state_d = S_COUNT;
        end
      end
      default: state_d = S_ERROR;
    endcase
  end

  assign sram_wr_en  = wr_en_q;
  assign sram_addr   = addr_q;
  assign sram_din    = din_q;
  assign proc_resetn = proc_rstn_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected SRAM writes are queued by the
// stimulus and checked by an independent write monitor; status is checked directly.
module tb_uart_program_loader;
  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rx = 1'b1;
  logic       reload = 1'b0;
  logic       sram_wr_en;
  logic [6:0] sram_addr;
  logic [8:0] sram_din;
  logic       proc_resetn, busy, error;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(7), .DATA_W(9)) dut (
    .clock(clock), .resetn(resetn), .rx(rx), .reload(reload),
    .sram_wr_en(sram_wr_en), .sram_addr(sram_addr), .sram_din(sram_din),
    .proc_resetn(proc_resetn), .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = -1;
  int rise_cyc = -1;
  logic prev_pr = 1'b0;
  logic [15:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clock) begin
    logic [15:0] e;
    if (resetn === 1'b1 && sram_wr_en === 1'b1) begin
      n_cmp++;
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0h din=%0h, none expected", sram_addr, sram_din);
      end else begin
        e = exp_q.pop_front();
        if ({sram_addr, sram_din} !== e)
          begin
            n_bad++;
            $display("FAIL write: got addr=%0h din=%0h, expected addr=%0h din=%0h",
                     sram_addr, sram_din, e[15:9], e[8:0]);
          end
      end
    end
    if (proc_resetn === 1'b1 && prev_pr === 1'b0) rise_cyc = cyc;
    prev_pr = proc_resetn;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string nm, input int pr, input int bz, input int er);
    chk({nm, "_proc_resetn"}, int'(proc_resetn), pr);
    chk({nm, "_busy"}, int'(busy), bz);
    chk({nm, "_error"}, int'(error), er);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [6:0] a, input logic [8:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    idle(3);
    chk("rst_wr_en", int'(sram_wr_en), 0);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_din", int'(sram_din), 0);
    chk_status("rst", 0, 1, 0);
    resetn = 1'b1;
    idle(3);

    // Basic two-word image.
    wr_cnt = 0;
    push(7'd0, 9'h15A);
    push(7'd1, 9'h0C3);
    sb(8'h02); sb(8'h5A); sb(8'h01); sb(8'hC3); sb(8'h00);
    idle(4);
    chk_status("basic", 1, 0, 0);
    chk("basic_addr", int'(sram_addr), 1);
    chk("basic_nwr", wr_cnt, 2);
    chk("basic_pending", exp_q.size(), 0);
    chk("basic_release_latency", rise_cyc, last_wr_cyc + 1);

    // Bytes after DONE are ignored.
    sb(8'h03); sb(8'h44);
    idle(4);
    chk_status("done_ignore", 1, 0, 0);

    pulse_reload();
    chk_status("reload", 0, 1, 0);
    chk("reload_addr", int'(sram_addr), 0);

    // Oversized count.
    sb(8'h81);
    idle(4);
    chk_status("cnt81", 0, 0, 1);

    // Reload from ERROR, glitch rejection, then a one-word image.
    pulse_reload();
    chk_status("reload_err", 0, 1, 0);
    @(negedge clock) rx = 1'b0;
    @(negedge clock) rx = 1'b1;
    idle(40);
    chk_status("glitch", 0, 1, 0);
    push(7'd0, 9'h1FF);
    sb(8'h01); sb(8'hFF); sb(8'h01);
    idle(4);
    chk_status("one_word", 1, 0, 0);
    chk("one_word_addr", int'(sram_addr), 0);

    // Reload during LO has no effect.
    pulse_reload();
    push(7'd0, 9'h034);
    push(7'd1, 9'h156);
    sb(8'h02);
    pulse_reload();
    chk_status("reload_in_lo", 0, 1, 0);
    sb(8'h34); sb(8'h00); sb(8'h56); sb(8'h01);
    idle(4);
    chk_status("reload_in_lo_done", 1, 0, 0);
    chk("reload_in_lo_addr", int'(sram_addr), 1);

    // Illegal HI byte.
    pulse_reload();
    sb(8'h01); sb(8'h11); sb(8'h02);
    idle(4);
    chk_status("hi_bad", 0, 0, 1);

    // Framing error on the count byte and on a data byte.
    pulse_reload();
    send_byte(8'h01, 1'b0);
    idle(4);
    chk_status("stop0_count", 0, 0, 1);
    pulse_reload();
    sb(8'h01);
    send_byte(8'h22, 1'b0);
    idle(4);
    chk_status("stop0_lo", 0, 0, 1);

    // Asynchronous reset in the middle of a HI byte.
    pulse_reload();
    push(7'd0, 9'h110);
    sb(8'h02); sb(8'h10); sb(8'h01); sb(8'h22);
    @(negedge clock) rx = 1'b0;
    idle(20);
    #2 resetn = 1'b0;
    #1;
    chk("arst_wr_en", int'(sram_wr_en), 0);
    chk("arst_addr", int'(sram_addr), 0);
    chk("arst_din", int'(sram_din), 0);
    chk_status("arst", 0, 1, 0);
    rx = 1'b1;
    idle(3);
    resetn = 1'b1;
    idle(3);
    push(7'd0, 9'h005);
    sb(8'h01); sb(8'h05); sb(8'h00);
    idle(4);
    chk_status("after_arst", 1, 0, 0);
    chk("after_arst_pending", exp_q.size(), 0);

    // Full 128-word image, data = index.
    pulse_reload();
    wr_cnt = 0;
    for (int i = 0; i < 128; i++) push(7'(i), 9'(i));
    sb(8'h00);
    for (int i = 0; i < 128; i++) begin
      sb(8'(i));
      sb(8'h00);
    end
    idle(4);
    chk_status("full", 1, 0, 0);
    chk("full_addr", int'(sram_addr), 127);
    chk("full_nwr", wr_cnt, 128);
    chk("full_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
